// File: rtl/rot_coord_gen.sv
// Destination-to-source coordinate generator: fetches cos/sin coefficients for the
// selected angle, then raster-scans the image and emits inverse-rotated source coordinates.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | lookup indices presented, lookups registering
// LATCH | coefficients captured, scan counters cleared
// RUN   | issuing one pixel per advancing cycle
// DRAIN | waiting for the final beat to be accepted
module rot_coord_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         aci,
  output logic [2:0]         cos_idx,
  output logic [2:0]         sin_idx,
  input  logic signed [16:0] cos_in,
  input  logic signed [16:0] sin_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      dst_x,
  output logic [CW-1:0]      dst_y,
  output logic [CW-1:0]      src_x,
  output logic [CW-1:0]      src_y,
  output logic               in_range
);

  localparam int PW = CW + 18;
  localparam int SW = PW + 1;
  localparam logic [CW-1:0]        XMAX   = CW'(IMG_W - 1);
  localparam logic [CW-1:0]        YMAX   = CW'(IMG_H - 1);
  localparam logic signed [CW:0]   XOFF   = (CW+1)'(IMG_W / 2);
  localparam logic signed [CW:0]   YOFF   = (CW+1)'(IMG_H / 2);
  localparam logic signed [SW-1:0] RND    = SW'(512);
  localparam logic signed [17:0]   SX_OFF = 18'(IMG_W / 2);
  localparam logic signed [17:0]   SY_OFF = 18'(IMG_H / 2);
  localparam logic signed [17:0]   SX_LIM = 18'(IMG_W);
  localparam logic signed [17:0]   SY_LIM = 18'(IMG_H);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic                 accept, reject, latch_en, issue, finish;
  logic                 adv, last_pix, final_hs;

  logic signed [16:0]   c_q, s_q;
  logic [CW-1:0]        x_cnt, y_cnt;

  logic                 s1_v;
  logic [CW-1:0]        s1_x, s1_y;
  logic signed [CW:0]   s1_xc, s1_yc;

  logic                 s2_v;
  logic [CW-1:0]        s2_x, s2_y;
  logic signed [PW-1:0] p_xc_c, p_yc_s, p_xc_s, p_yc_c;

  logic signed [SW-1:0] xs_w, ys_w, xr_w, yr_w;
  logic signed [17:0]   sx_w, sy_w;
  logic                 in_w;

  assign adv      = !out_valid || out_ready;
  assign last_pix = (x_cnt == XMAX) && (y_cnt == YMAX);
  // The last beat is accepted once nothing is left behind it in the pipe.
  assign final_hs = out_valid && out_ready && !s1_v && !s2_v;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (aci != 3'd7)) state_nxt = FETCH;
      FETCH:   state_nxt = LATCH;
      LATCH:   state_nxt = RUN;
      RUN:     if (adv && last_pix) state_nxt = DRAIN;
      DRAIN:   if (final_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    reject   = 1'b0;
    latch_en = 1'b0;
    issue    = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        accept = start && (aci != 3'd7);
        reject = start && (aci == 3'd7);
      end
      LATCH:   latch_en = 1'b1;
      RUN:     issue    = adv;
      DRAIN:   finish   = final_hs;
      default: ;
    endcase
  end

  always_comb begin
    xs_w = SW'(p_xc_c) + SW'(p_yc_s);
    ys_w = SW'(p_yc_c) - SW'(p_xc_s);
    xr_w = (xs_w + RND) >>> 10;
    yr_w = (ys_w + RND) >>> 10;
    sx_w = $signed(xr_w[17:0]) + SX_OFF;
    sy_w = $signed(yr_w[17:0]) + SY_OFF;
    in_w = !sx_w[17] && (sx_w < SX_LIM) && !sy_w[17] && (sy_w < SY_LIM);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cos_idx   <= '0;
      sin_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      c_q       <= '0;
      s_q       <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      s1_v      <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_xc     <= '0;
      s1_yc     <= '0;
      s2_v      <= 1'b0;
      s2_x      <= '0;
      s2_y      <= '0;
      p_xc_c    <= '0;
      p_yc_s    <= '0;
      p_xc_s    <= '0;
      p_yc_c    <= '0;
      out_valid <= 1'b0;
      dst_x     <= '0;
      dst_y     <= '0;
      src_x     <= '0;
      src_y     <= '0;
      in_range  <= 1'b0;
    end else begin
      err  <= reject;
      done <= finish;
      if (accept) begin
        cos_idx <= aci;
        // sine comes from the cosine table at the complementary angle
        sin_idx <= 3'd6 - aci;
        busy    <= 1'b1;
      end else if (finish) begin
        busy    <= 1'b0;
      end

      if (latch_en) begin
        c_q   <= cos_in;
        s_q   <= sin_in;
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (issue) begin
        if (x_cnt == XMAX) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == YMAX) ? '0 : y_cnt + CW'(1);
        end else begin
          x_cnt <= x_cnt + CW'(1);
        end
      end

      if (adv) begin
        s1_v <= issue;
        if (issue) begin
          s1_x  <= x_cnt;
          s1_y  <= y_cnt;
          s1_xc <= $signed({1'b0, x_cnt}) - XOFF;
          s1_yc <= $signed({1'b0, y_cnt}) - YOFF;
        end

        s2_v <= s1_v;
        if (s1_v) begin
          s2_x   <= s1_x;
          s2_y   <= s1_y;
          p_xc_c <= PW'(s1_xc) * PW'(c_q);
          p_yc_s <= PW'(s1_yc) * PW'(s_q);
          p_xc_s <= PW'(s1_xc) * PW'(s_q);
          p_yc_c <= PW'(s1_yc) * PW'(c_q);
        end

        out_valid <= s2_v;
        if (s2_v) begin
          dst_x    <= s2_x;
          dst_y    <= s2_y;
          src_x    <= in_w ? sx_w[CW-1:0] : '0;
          src_y    <= in_w ? sy_w[CW-1:0] : '0;
          in_range <= in_w;
        end
      end
    end
  end

endmodule

// File: doc/rot_coord_gen.md
# rot_coord_gen

Destination-to-source coordinate generator for the image rotation datapath. It sits directly downstream of the cosine lookup stage. It drives the lookup's 3-bit angle index for both the cosine and sine instances, and captures their Q7.10 outputs. It then raster-scans the destination image and emits, per pixel, the inverse-rotated source coordinate with an in-range flag for the pixel fetch stage.

## Interface
- IMG_W, 64: image width in pixels; even, ≤ 2^CW.
- IMG_H, 64: image height in pixels; even, ≤ 2^CW.
- CW, 8: coordinate width in bits.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset. reset==0 at a clk edge clears all state.
- start  in  1  run request; sampled only in IDLE.
- aci  in  3  angle code, 0..6 = 0°..90° in 15° steps.
- cos_idx  out  3  index to the cosine lookup instance; reset 0.
- sin_idx  out  3  index to the second lookup instance, which provides sine; reset 0.
- cos_in  in  17  signed Q7.10 from the cosine lookup; one-cycle registered latency.
- sin_in  in  17  signed Q7.10 from the sine lookup; one-cycle registered latency.
- busy  out  1  high from start acceptance until the done cycle; reset 0.
- done  out  1  one-cycle pulse at the end of a run; reset 0.
- err  out  1  one-cycle pulse when start arrives with aci==7; reset 0.
- out_valid  out  1  output beat valid; reset 0.
- out_ready  in  1  downstream accept.
- dst_x  out  CW  destination x of the current beat; reset 0.
- dst_y  out  CW  destination y of the current beat; reset 0.
- src_x  out  CW  source x; 0 when in_range==0; reset 0.
- src_y  out  CW  source y; 0 when in_range==0; reset 0.
- in_range  out  1  source coordinate lies inside the image; reset 0.

## Operation
- FSM states: IDLE, FETCH, LATCH, RUN, DRAIN.
- IDLE:
  - start=1 with aci≤6: latch aci, set busy, go to FETCH.
  - start=1 with aci==7: pulse err and stay in IDLE.
- FETCH:
  - cos_idx = aci_latched.
  - sin_idx = 6 − aci_latched, using sin θ = cos(90° − θ).
  - Go to LATCH.
- LATCH: capture cos_in and sin_in into coefficient registers c and s. Clear the x and y counters. Go to RUN.
- RUN:
  - Raster scan: x is the inner loop (0..IMG_W−1), y the outer loop.
  - The counters advance only when the pipeline advances.
  - After the pixel (IMG_W−1, IMG_H−1) is issued, go to DRAIN.
- DRAIN: wait until the final beat has been handshaken, pulse done, clear busy, go to IDLE.
- Pipeline, 3 register stages. Advance condition adv = !out_valid || out_ready. All stages and the counters hold when adv==0.
  - S1: xc = x − IMG_W/2 and yc = y − IMG_H/2, as signed CW+1 bits. Pass x and y along.
  - S2: four signed products xc·c, yc·s, xc·s, yc·c, each 26 bits.
  - S3:
    - xs = xc·c + yc·s.
    - ys = yc·c − xc·s.
    - Both are 27-bit signed.
    - Round each: (v + 512) >>> 10 (arithmetic shift, round half up).
    - Add IMG_W/2 to the rounded xs and IMG_H/2 to the rounded ys, in signed 18 bits.
    - in_range = 0 ≤ sx < IMG_W && 0 ≤ sy < IMG_H.
    - src_x/src_y are the low CW bits when in range, else 0.
- A bubble-free pipeline sets out_valid only for real pixels. Fill cycles are not emitted.
- start while busy: ignored.
- aci changes during a run: no effect, because the coefficients were latched.
- reset==0 at any point, including mid-run or mid-stall: every output goes to its reset value, the FSM goes to IDLE, and partial results are discarded.

## Timing
- Edge E0 samples start in IDLE.
- FETCH occupies E0→E1; the lookups register on E1.
- LATCH captures the coefficients on E2, and the counter presents (0,0).
- First out_valid is registered on E5, i.e. 5 cycles after the accepting edge.
- With out_ready held high: one beat per cycle, W·H beats.
- done is registered on the edge after the last handshake, at E0 + 5 + W·H.
- A stall (out_ready=0 with out_valid=1) freezes all outputs unchanged until accepted. No beat is lost or duplicated.
- err is registered on the edge after start is sampled with aci==7.

## Test plan
- aci=0 (c=1024, s=0), 64×64, out_ready=1 → src equals dst for all 4096 beats and in_range is all 1. done occurs 4101 cycles after start.
- aci=6 (c=0, s=1024):
  - dst (0,0) → in_range=0, src=(0,0).
  - dst (1,0) → src=(0,63), in_range=1.
- aci=4 (c=512, s=886):
  - dst (32,32) → src (32,32).
  - dst (42,32) → src (37,23) in range.
- Random out_ready toggling at aci=3 → beat sequence identical to the no-stall golden model, and outputs stay stable while stalled.
- start with aci=7 → err pulses once, busy stays 0, out_valid never rises. A start during busy is ignored.
- reset=0 held for one cycle mid-RUN → all outputs 0 the next cycle. A fresh start then produces a full correct run.
